acc_trigger_packer: RTL and testbench
=====================================

Name: acc_trigger_packer

Overview:
- Upstream feeder of the accumulated-trigger dump path, in the PMT/timing clock domain.
- Detects trigger edges while a scan is active and timestamps each one.
- Packs four 64-bit event records into one 256-bit word and drives the latch strobe/data pair that writes the cross-clock dump FIFO.
- At scan end, flushes any partial word, then emits a summary word so DDR readback can delimit scans.

Parameters:
- TCQ, 0.1, register clock-to-q delay for simulation.
- REC_TAG, 4'hA, tag in bits [63:60] of every event record.
- END_TAG, 4'hF, tag in bits [255:252] of the end-of-scan summary word.

Ports:
- clk_i  input  1  PMT/timing clock; same clock as the dump FIFO write side.
- rst_n_i  input  1  asynchronous, active-low reset.
- pmt_scan_en_i  input  1  scan-active level.
- acc_trigger_i  input  1  accumulation trigger level; an event is its rising edge.
- acc_data_i  input  16  accumulator value captured with each event.
- acc_fifo_full_i  input  1  dump FIFO full flag.
- acc_trigger_latch_en_o  output  1  one-cycle write strobe to the dump FIFO.
- acc_trigger_latch_o  output  256  packed word, valid only while the strobe is high.
- trig_cnt_o  output  32  events accepted in the current or last scan.
- drop_cnt_o  output  16  words dropped because the FIFO was full.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, slot=0, ts=0, trig_d=0. Reset is asynchronous, active-low.
- Event definition: acc_trigger_i=1 and trig_d=0, where trig_d is acc_trigger_i registered every cycle in all states. An event is accepted only in RUN with pmt_scan_en_i=1 in the same cycle.
- Timestamp ts, 32 bits:
  - cleared on the IDLE->RUN transition, so it is 0 in the first RUN cycle;
  - increments by 1 every RUN cycle and wraps 0xFFFFFFFF->0 silently;
  - holds outside RUN.
- Event record, 64 bits: {REC_TAG, seq[11:0], acc_data_i, ts}.
  - seq = trig_cnt_o[11:0] before the increment; the first event of a scan has seq=0.
  - trig_cnt_o increments by 1 per accepted event and saturates at 0xFFFFFFFF.
- Packing:
  - slot k (0..3) occupies bits [64k+63:64k];
  - the record is written into slot[1:0] and slot advances;
  - when slot 3 is filled, the word is emitted the next cycle: latch_en_o=1 with latch_o equal to the 4 records, and slot returns to 0;
  - latency from the 4th event to the strobe is 1 clk;
  - a new event can be accepted in the same cycle a word is emitted, with no back-to-back loss.
- Emit rule, applied to every word (data, partial, summary):
  - if acc_fifo_full_i=1 in the emit cycle, the strobe stays 0, the word is discarded, and drop_cnt_o increments (saturating at 0xFFFF);
  - there are no retries.
- FSM transitions:
  - IDLE: pmt_scan_en_i=1 -> RUN, clearing ts, slot, the holding word, trig_cnt_o and drop_cnt_o.
  - RUN: pmt_scan_en_i=0 -> FLUSH. An event in that same cycle is ignored.
  - FLUSH, 1 cycle: if slot>0, emit the partial word with unused slots = 64'h0. Then -> SUMMARY.
  - SUMMARY, 1 cycle: emit {END_TAG, 60'h0, 32'(trig_cnt_o), 16'(drop_cnt_o as of this cycle), 144'h0}. Then -> IDLE.
- Summary word field positions:
  - bits [191:160] = trig_cnt_o;
  - bits [159:144] = drop_cnt_o;
  - all other bits 0 except the tag.
- Scan re-assert during FLUSH/SUMMARY: ignored. IDLE samples the level and re-enters RUN on the next cycle, so the minimum scan gap is 3 cycles.
- Cycle placement: the partial word is driven in the FLUSH cycle; the summary word is driven in the SUMMARY cycle.
- trig_cnt_o and drop_cnt_o hold their values through IDLE until the next scan start.
- Reset mid-scan: immediate return to reset values; no flush and no summary.

Test Plan:
- Scan high for 100 cycles; 8 isolated trigger pulses at ts=5,10,...,40 -> 2 data strobes, each 1 clk after the 4th/8th event. Word0 slot0 = {A,000,data,00000005}. Then the summary word with trig_cnt=8, drop=0, and no partial word.
- 6 events, then scan falls -> strobes: word(4), partial with slots 2/3 = 0 in FLUSH, summary in SUMMARY showing trig_cnt=6.
- acc_fifo_full_i=1 during the 1st word's emit cycle, 8 events -> only the 2nd word is strobed, drop_cnt_o=1, summary bits[159:144]=1.
- acc_trigger_i held high 20 cycles -> exactly 1 event. A trigger edge coinciding with the scan falling edge -> not counted.
- Force ts near 0xFFFFFFFE via a long scan/preload and trigger across the wrap -> timestamps ...FE, ...FF, 0 with no glitch.
- rst_n_i pulsed low with slot=2 mid-scan -> outputs 0 asynchronously, no strobe afterwards; the next scan's first record has seq=0.

Source files
------------

// File: rtl/acc_trigger_packer_if.sv
// Bus bundle between the trigger source / dump FIFO side and acc_trigger_packer.
// The packer takes the slave view; the stimulus or integration shell takes master.
interface acc_trigger_packer_if;
  logic         pmt_scan_en_i;
  logic         acc_trigger_i;
  logic [15:0]  acc_data_i;
  logic         acc_fifo_full_i;
  logic         acc_trigger_latch_en_o;
  logic [255:0] acc_trigger_latch_o;
  logic [31:0]  trig_cnt_o;
  logic [15:0]  drop_cnt_o;
  logic         busy_o;

  modport master (
    output pmt_scan_en_i, acc_trigger_i, acc_data_i, acc_fifo_full_i,
    input  acc_trigger_latch_en_o, acc_trigger_latch_o, trig_cnt_o, drop_cnt_o, busy_o
  );

  modport slave (
    input  pmt_scan_en_i, acc_trigger_i, acc_data_i, acc_fifo_full_i,
    output acc_trigger_latch_en_o, acc_trigger_latch_o, trig_cnt_o, drop_cnt_o, busy_o
  );
endinterface

// File: rtl/acc_trigger_packer.sv
// Timestamps trigger edges during a scan, packs four 64-bit records per 256-bit
// dump word, then flushes the partial word and emits an end-of-scan summary.
module acc_trigger_packer #(
  parameter real        TCQ     = 0.1,
  parameter logic [3:0] REC_TAG = 4'hA,
  parameter logic [3:0] END_TAG = 4'hF
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  acc_trigger_packer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    SUMMARY = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           trig_d_r;
  logic [31:0]    ts_r;
  logic [1:0]     slot_r;
  logic [255:0]   hold_r;
  logic [255:0]   word_r;
  logic           pend_r;
  logic [31:0]    trig_cnt_r;
  logic [15:0]    drop_cnt_r;

  logic           start_s;
  logic           flush_s;
  logic           event_s;
  logic           emit_s;
  logic           drop_s;
  logic [63:0]    record_s;
  logic [255:0]   filled_s;
  logic [255:0]   summary_s;

  assign start_s  = (state_r == IDLE) && bus.pmt_scan_en_i;
  // Scan falling in RUN wins over a coincident trigger edge.
  assign flush_s  = (state_r == RUN) && !bus.pmt_scan_en_i;
  assign event_s  = (state_r == RUN) && bus.pmt_scan_en_i && bus.acc_trigger_i && !trig_d_r;
  assign record_s = {REC_TAG, trig_cnt_r[11:0], bus.acc_data_i, ts_r};
  assign summary_s = {END_TAG, 60'h0, trig_cnt_r, drop_cnt_r, 144'h0};
  assign emit_s   = pend_r || (state_r == SUMMARY);
  assign drop_s   = emit_s && bus.acc_fifo_full_i;

  // Holding word with the incoming record merged into the current slot
  always_comb begin
    filled_s = hold_r;
    case (slot_r)
      2'd0:    filled_s[63:0]    = record_s;
      2'd1:    filled_s[127:64]  = record_s;
      2'd2:    filled_s[191:128] = record_s;
      2'd3:    filled_s[255:192] = record_s;
      default: filled_s          = hold_r;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.pmt_scan_en_i) state_nxt_s = RUN;
        else                   state_nxt_s = IDLE;
      end
      RUN: begin
        if (!bus.pmt_scan_en_i) state_nxt_s = FLUSH;
        else                    state_nxt_s = RUN;
      end
      FLUSH:   state_nxt_s = SUMMARY;
      SUMMARY: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Trigger delay for edge detection, sampled in every state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) trig_d_r <= 1'b0;
    else          trig_d_r <= bus.acc_trigger_i;
  end

  // Timestamp: zero in the first RUN cycle, free-running with wrap inside RUN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              ts_r <= 32'd0;
    else if (start_s)          ts_r <= 32'd0;
    else if (state_r == RUN)   ts_r <= ts_r + 32'd1;
    else                       ts_r <= ts_r;
  end

  // Record packing; a full or partial word is parked in word_r for one emit cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_r <= 2'd0;
      hold_r <= 256'h0;
      word_r <= 256'h0;
      pend_r <= 1'b0;
    end else begin
      pend_r <= 1'b0;
      if (start_s) begin
        slot_r <= 2'd0;
        hold_r <= 256'h0;
      end else if (event_s) begin
        if (slot_r == 2'd3) begin
          word_r <= filled_s;
          pend_r <= 1'b1;
          hold_r <= 256'h0;
          slot_r <= 2'd0;
        end else begin
          hold_r <= filled_s;
          slot_r <= slot_r + 2'd1;
        end
      end else if (flush_s) begin
        if (slot_r != 2'd0) begin
          word_r <= hold_r;
          pend_r <= 1'b1;
        end
        hold_r <= 256'h0;
        slot_r <= 2'd0;
      end
    end
  end

  // Event and drop counters, cleared at scan start and held through IDLE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else if (start_s) begin
      trig_cnt_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (event_s && (trig_cnt_r != 32'hFFFF_FFFF)) trig_cnt_r <= trig_cnt_r + 32'd1;
      if (drop_s && (drop_cnt_r != 16'hFFFF))       drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  // The strobe is gated by the FIFO full flag of the emit cycle itself.
  assign bus.acc_trigger_latch_en_o = emit_s && !bus.acc_fifo_full_i;
  assign bus.acc_trigger_latch_o    = (state_r == SUMMARY) ? summary_s : word_r;
  assign bus.trig_cnt_o             = trig_cnt_r;
  assign bus.drop_cnt_o             = drop_cnt_r;
  assign bus.busy_o                 = (state_r != IDLE);

endmodule

// File: tb/tb_acc_trigger_packer.sv
// Directed bench for acc_trigger_packer: packing, flush, summary, full-drop,
// edge detection, timestamp wrap and mid-scan reset.
module tb_acc_trigger_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   strobe_cnt = 0;
  int   s0;

  acc_trigger_packer_if bus ();

  acc_trigger_packer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Count strobes in the middle of each low phase
  always @(negedge clk) begin
    #2;
    if (bus.acc_trigger_latch_en_o === 1'b1) strobe_cnt++;
  end

  function automatic logic [63:0] rec(input logic [11:0] s, input logic [15:0] d,
                                      input logic [31:0] ts);
    return {4'hA, s, d, ts};
  endfunction

  function automatic logic [255:0] sumw(input logic [31:0] t, input logic [15:0] dr);
    return {4'hF, 60'h0, t, dr, 144'h0};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic scan, input logic trig, input logic [15:0] d,
                       input logic full);
    @(negedge clk);
    bus.pmt_scan_en_i   = scan;
    bus.acc_trigger_i   = trig;
    bus.acc_data_i      = d;
    bus.acc_fifo_full_i = full;
    #1;
  endtask

  initial begin
    bus.pmt_scan_en_i   = 1'b0;
    bus.acc_trigger_i   = 1'b0;
    bus.acc_data_i      = 16'h0;
    bus.acc_fifo_full_i = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_latch_en", 256'(bus.acc_trigger_latch_en_o), 256'd0);
    check("rst_latch", bus.acc_trigger_latch_o, 256'd0);
    check("rst_trig_cnt", 256'(bus.trig_cnt_o), 256'd0);
    check("rst_drop_cnt", 256'(bus.drop_cnt_o), 256'd0);
    check("rst_busy", 256'(bus.busy_o), 256'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Scan 1: 8 pulses at ts=5..40, two full words, no partial
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    s0 = strobe_cnt;
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, (t % 5 == 0) && (t >= 5) && (t <= 40), 16'h1000 + 16'(t), 1'b0);
      if (t == 0) check("s1_busy", 256'(bus.busy_o), 256'd1);
      if (t == 20) check("s1_no_early_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd0);
      if (t == 21) begin
        check("s1_w0_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
        check("s1_w0", bus.acc_trigger_latch_o,
              {rec(12'd3, 16'h1014, 32'd20), rec(12'd2, 16'h100F, 32'd15),
               rec(12'd1, 16'h100A, 32'd10), rec(12'd0, 16'h1005, 32'd5)});
      end
      if (t == 41) begin
        check("s1_w1_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
        check("s1_w1", bus.acc_trigger_latch_o,
              {rec(12'd7, 16'h1028, 32'd40), rec(12'd6, 16'h1023, 32'd35),
               rec(12'd5, 16'h101E, 32'd30), rec(12'd4, 16'h1019, 32'd25)});
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s1_flush_no_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd0);
    check("s1_flush_busy", 256'(bus.busy_o), 256'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s1_sum_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
    check("s1_sum", bus.acc_trigger_latch_o, sumw(32'd8, 16'd0));
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s1_idle_busy", 256'(bus.busy_o), 256'd0);
    check("s1_idle_trig_hold", 256'(bus.trig_cnt_o), 256'd8);
    check("s1_strobes", 256'(strobe_cnt - s0), 256'd3);

    // Scan 2: 6 events -> one word, partial in FLUSH, summary
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    s0 = strobe_cnt;
    for (int t = 0; t < 14; t++) begin
      drive(1'b1, (t >= 2) && (t <= 12) && (t % 2 == 0), 16'h2000 + 16'(t), 1'b0);
      if (t == 0) check("s2_trig_cleared", 256'(bus.trig_cnt_o), 256'd0);
      if (t == 9) check("s2_w0", bus.acc_trigger_latch_o,
                        {rec(12'd3, 16'h2008, 32'd8), rec(12'd2, 16'h2006, 32'd6),
                         rec(12'd1, 16'h2004, 32'd4), rec(12'd0, 16'h2002, 32'd2)});
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s2_partial_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
    check("s2_partial", bus.acc_trigger_latch_o,
          {128'h0, rec(12'd5, 16'h200C, 32'd12), rec(12'd4, 16'h200A, 32'd10)});
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s2_sum", bus.acc_trigger_latch_o, sumw(32'd6, 16'd0));
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s2_strobes", 256'(strobe_cnt - s0), 256'd3);

    // Scan 3: FIFO full during the first word's emit cycle
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    s0 = strobe_cnt;
    for (int t = 0; t < 17; t++) begin
      drive(1'b1, (t % 2 == 1), 16'h4000 + 16'(t), (t == 8));
      if (t == 8) check("s3_full_no_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd0);
      if (t == 9) check("s3_drop_cnt", 256'(bus.drop_cnt_o), 256'd1);
      if (t == 16) begin
        check("s3_w1_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
        check("s3_w1", bus.acc_trigger_latch_o,
              {rec(12'd7, 16'h400F, 32'd15), rec(12'd6, 16'h400D, 32'd13),
               rec(12'd5, 16'h400B, 32'd11), rec(12'd4, 16'h4009, 32'd9)});
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s3_sum", bus.acc_trigger_latch_o, sumw(32'd8, 16'd1));
    check("s3_sum_drop_field", 256'(bus.acc_trigger_latch_o[159:144]), 256'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s3_strobes", 256'(strobe_cnt - s0), 256'd2);

    // Scan 4: level held 20 cycles is one event; edge at scan fall is ignored
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    s0 = strobe_cnt;
    for (int t = 0; t < 25; t++) begin
      drive(1'b1, (t >= 2) && (t <= 21), 16'h3333, 1'b0);
      if (t == 24) check("s4_held_one_event", 256'(bus.trig_cnt_o), 256'd1);
    end
    drive(1'b0, 1'b1, 16'h3333, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s4_fall_edge_ignored", 256'(bus.trig_cnt_o), 256'd1);
    check("s4_partial", bus.acc_trigger_latch_o, {192'h0, rec(12'd0, 16'h3333, 32'd2)});
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s4_sum", bus.acc_trigger_latch_o, sumw(32'd1, 16'd0));
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s4_strobes", 256'(strobe_cnt - s0), 256'd2);

    // Scan 5: timestamp preloaded just below wrap
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    force dut.ts_r = 32'hFFFF_FFFC;
    #1;
    release dut.ts_r;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, (k % 2 == 1), 16'h5000 + 16'(k), 1'b0);
      if (k == 8) begin
        check("s5_wrap_strobe", 256'(bus.acc_trigger_latch_en_o), 256'd1);
        check("s5_wrap_word", bus.acc_trigger_latch_o,
              {rec(12'd3, 16'h5007, 32'd4), rec(12'd2, 16'h5005, 32'd2),
               rec(12'd1, 16'h5003, 32'd0), rec(12'd0, 16'h5001, 32'hFFFF_FFFE)});
      end
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s5_sum", bus.acc_trigger_latch_o, sumw(32'd4, 16'd0));
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Scan 6: async reset with two records pending, then a clean scan
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, (t == 1) || (t == 3), 16'h6000 + 16'(t), 1'b0);
    end
    check("s6_pre_reset_cnt", 256'(bus.trig_cnt_o), 256'd2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_busy", 256'(bus.busy_o), 256'd0);
    check("s6_rst_trig_cnt", 256'(bus.trig_cnt_o), 256'd0);
    check("s6_rst_latch_en", 256'(bus.acc_trigger_latch_en_o), 256'd0);
    s0 = strobe_cnt;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) drive(1'b0, 1'b0, 16'h0, 1'b0);
    check("s6_no_strobe_after_rst", 256'(strobe_cnt - s0), 256'd0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int t = 0; t < 9; t++) begin
      drive(1'b1, (t % 2 == 1), 16'h7000 + 16'(t), 1'b0);
      if (t == 8) check("s6_next_scan_word", bus.acc_trigger_latch_o,
                        {rec(12'd3, 16'h7007, 32'd7), rec(12'd2, 16'h7005, 32'd5),
                         rec(12'd1, 16'h7003, 32'd3), rec(12'd0, 16'h7001, 32'd1)});
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
